simon_data_out: RTL and testbench

//  Output packetiser at the back end of the SIMON datapath. Collects two

---
 rtl/simon_data_out_if.sv | 25 ++
 rtl/simon_data_out.sv | 109 ++++++++++
 tb/tb_simon_data_out.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/simon_data_out_if.sv
// Handshake/bus bundle between the SIMON core, the output packetiser and the host.
// slave  : the packetiser (consumes result blocks, presents packets)
// master : the core/host side driving blocks and acknowledging packets
interface simon_data_out_if #(
   parameter int N = 16
);
   logic                 doneDATA;
   logic [1:0][N-1:0]    outDATA;
   logic [7:0]           infoOUT;
   logic [7:0]           countOUT;
   logic                 readPKT;
   logic                 readDATA;
   logic                 donePKT;
   logic [N/2+1:0][7:0]  out;

   modport master (
      output doneDATA, outDATA, infoOUT, countOUT, readPKT,
      input  readDATA, donePKT, out
   );

   modport slave (
      input  doneDATA, outDATA, infoOUT, countOUT, readPKT,
      output readDATA, donePKT, out
   );
endinterface

// File: rtl/simon_data_out.sv
// SIMON output packetiser: gathers two result blocks from the cipher core,
// prefixes info and count bytes, and holds the packet for the host.
// Optional build macro SIMON_DATAOUT_CLR_EN: clear the packet bytes on host ack.
module simon_data_out #(
   parameter int N = 16
) (
   input  logic            clk,
   input  logic            nR,
   simon_data_out_if.slave bus
);

   typedef enum logic [2:0] {
      WAIT0 = 3'd0,
      HOLD0 = 3'd1,
      WAIT1 = 3'd2,
      HOLD1 = 3'd3,
      FULL  = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [N/2+1:0][7:0]  out_q, out_d;
   logic                 read_data_q, read_data_d;
   logic                 done_pkt_q, done_pkt_d;

   // Next-state and next-output decode; readDATA defaults low so it is a single-cycle pulse.
   always_comb begin
      state_d     = state_q;
      out_d       = out_q;
      read_data_d = 1'b0;
      done_pkt_d  = done_pkt_q;
      case (state_q)
         WAIT0: begin
            if (bus.doneDATA) begin
               out_d[N/2+1]         = bus.infoOUT;
               out_d[N/2]           = bus.countOUT;
               out_d[N/2-1 -: N/4]  = {bus.outDATA[1], bus.outDATA[0]};
               read_data_d          = 1'b1;
               state_d              = HOLD0;
            end else begin
               state_d = WAIT0;
            end
         end
         HOLD0: begin
            // Wait for the core to drop doneDATA so one block is never captured twice.
            if (!bus.doneDATA) begin
               state_d = WAIT1;
            end else begin
               state_d = HOLD0;
            end
         end
         WAIT1: begin
            // Header bytes were taken with block0 and are deliberately not re-sampled.
            if (bus.doneDATA) begin
               out_d[N/4-1:0] = {bus.outDATA[1], bus.outDATA[0]};
               read_data_d    = 1'b1;
               state_d        = HOLD1;
            end else begin
               state_d = WAIT1;
            end
         end
         HOLD1: begin
            if (!bus.doneDATA) begin
               done_pkt_d = 1'b1;
               state_d    = FULL;
            end else begin
               state_d = HOLD1;
            end
         end
         FULL: begin
            // doneDATA is ignored here: readDATA stays low as backpressure.
            if (bus.readPKT) begin
               done_pkt_d = 1'b0;
               state_d    = WAIT0;
`ifdef SIMON_DATAOUT_CLR_EN
               out_d      = {(N/2+2){8'h00}};
`else
               out_d      = out_q;
`endif
            end else begin
               state_d = FULL;
            end
         end
         default: begin
            state_d    = WAIT0;
            done_pkt_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (nR) begin
         state_q     <= WAIT0;
         out_q       <= {(N/2+2){8'h00}};
         read_data_q <= 1'b0;
         done_pkt_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         read_data_q <= read_data_d;
         done_pkt_q  <= done_pkt_d;
      end
   end

   assign bus.readDATA = read_data_q;
   assign bus.donePKT  = done_pkt_q;
   assign bus.out      = out_q;

endmodule

// File: tb/tb_simon_data_out.sv
// Directed self-checking bench for simon_data_out (N=16, 10-byte packets).
module tb_simon_data_out;

   logic clk = 1'b0;
   logic nR;
   always #5 clk = ~clk;

   simon_data_out_if #(.N(16)) bus ();

   simon_data_out #(.N(16)) dut (
      .clk (clk),
      .nR  (nR),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0]  info;
      logic [7:0]  count;
      logic [31:0] b0;
      logic [31:0] b1;
      logic [79:0] exp_pkt;
   } vec_t;

   vec_t vecs [3];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp_v);
      end
   endtask

   // Present one block and hold doneDATA until readDATA appears, then release it.
   task automatic send_block(input logic [31:0] blk);
      logic seen;
      seen = 1'b0;
      bus.outDATA  = blk;
      bus.doneDATA = 1'b1;
      for (int i = 0; i < 8 && !seen; i++) begin
         step();
         if (bus.readDATA) seen = 1'b1;
      end
      chk("rd_pulse_seen", {79'd0, seen}, 80'd1);
      chk("rd_donepkt_overlap", {79'd0, bus.donePKT}, 80'd0);
      bus.doneDATA = 1'b0;
      step();
      chk("rd_single_cycle", {79'd0, bus.readDATA}, 80'd0);
   endtask

   task automatic ack_pkt(input logic [79:0] pkt);
      bus.readPKT = 1'b1;
      step();
      bus.readPKT = 1'b0;
      chk("ack_donepkt_low", {79'd0, bus.donePKT}, 80'd0);
`ifdef SIMON_DATAOUT_CLR_EN
      chk("ack_out_cleared", bus.out, 80'd0);
`else
      chk("ack_out_retained", bus.out, pkt);
`endif
   endtask

   initial begin
      logic [79:0] pkt;
      int pulses;

      vecs[0] = '{8'hA5, 8'h01, 32'h1234_5678, 32'h9ABC_DEF0, 80'hA5_01_1234_5678_9ABC_DEF0};
      vecs[1] = '{8'hFF, 8'h00, 32'h0000_0000, 32'hFFFF_FFFF, 80'hFF_00_0000_0000_FFFF_FFFF};
      vecs[2] = '{8'h5A, 8'h80, 32'h8000_0001, 32'h00FF_00FF, 80'h5A_80_8000_0001_00FF_00FF};

      bus.doneDATA = 1'b0;
      bus.outDATA  = 32'h0;
      bus.infoOUT  = 8'h00;
      bus.countOUT = 8'h00;
      bus.readPKT  = 1'b0;
      nR           = 1'b1;

      // Reset
      step();
      step();
      chk("rst_readDATA", {79'd0, bus.readDATA}, 80'd0);
      chk("rst_donePKT", {79'd0, bus.donePKT}, 80'd0);
      chk("rst_out", bus.out, 80'd0);
      nR = 1'b0;
      for (int i = 0; i < 3; i++) step();
      chk("idle_activity", {bus.out[9:2], bus.out[1:0]} | {78'd0, bus.readDATA, bus.donePKT}, 80'd0);

      // Table-driven packets
      for (int v = 0; v < 3; v++) begin
         bus.infoOUT  = vecs[v].info;
         bus.countOUT = vecs[v].count;
         send_block(vecs[v].b0);
         bus.infoOUT  = ~vecs[v].info;
         bus.countOUT = ~vecs[v].count;
         chk("mid_donepkt_low", {79'd0, bus.donePKT}, 80'd0);
         send_block(vecs[v].b1);
         chk("pkt_donepkt", {79'd0, bus.donePKT}, 80'd1);
         chk("pkt_out", bus.out, vecs[v].exp_pkt);
         bus.readPKT = 1'b0;
         step();
         chk("pkt_hold", bus.out, vecs[v].exp_pkt);
         ack_pkt(vecs[v].exp_pkt);
      end

      // Backpressure in FULL
      bus.infoOUT  = 8'hA5;
      bus.countOUT = 8'h01;
      send_block(32'h1234_5678);
      send_block(32'h9ABC_DEF0);
      pkt = 80'hA5_01_1234_5678_9ABC_DEF0;
      bus.infoOUT  = 8'h3C;
      bus.countOUT = 8'h02;
      bus.outDATA  = 32'hCAFE_BABE;
      bus.doneDATA = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_readDATA", {79'd0, bus.readDATA}, 80'd0);
         chk("bp_out", bus.out, pkt);
      end
      chk("bp_donePKT", {79'd0, bus.donePKT}, 80'd1);
      bus.readPKT = 1'b1;
      step();
      bus.readPKT = 1'b0;
      chk("bp_ack_donePKT", {79'd0, bus.donePKT}, 80'd0);
      chk("bp_ack_no_capture", {79'd0, bus.readDATA}, 80'd0);
      step();
      chk("bp_capture_pulse", {79'd0, bus.readDATA}, 80'd1);
      bus.doneDATA = 1'b0;
      step();
      chk("bp_pulse_end", {79'd0, bus.readDATA}, 80'd0);
      send_block(32'h0BAD_F00D);
      chk("bp_new_pkt", bus.out, 80'h3C_02_CAFE_BABE_0BAD_F00D);
      ack_pkt(80'h3C_02_CAFE_BABE_0BAD_F00D);

      // Sticky doneDATA on block0
      bus.infoOUT  = 8'h11;
      bus.countOUT = 8'h22;
      bus.outDATA  = 32'h0102_0304;
      bus.doneDATA = 1'b1;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (bus.readDATA) pulses++;
      end
      chk("sticky_pulses", 80'(pulses), 80'd1);
      bus.doneDATA = 1'b0;
      step();
      chk("sticky_no_pkt", {79'd0, bus.donePKT}, 80'd0);
      send_block(32'h0506_0708);
      chk("sticky_pkt", bus.out, 80'h11_22_0102_0304_0506_0708);
      ack_pkt(80'h11_22_0102_0304_0506_0708);

      // Reset mid-packet
      bus.infoOUT  = 8'h77;
      bus.countOUT = 8'h66;
      send_block(32'hDEAD_BEEF);
      nR = 1'b1;
      step();
      chk("midrst_out", bus.out, 80'd0);
      chk("midrst_flags", {78'd0, bus.readDATA, bus.donePKT}, 80'd0);
      nR = 1'b0;
      bus.infoOUT  = 8'h88;
      bus.countOUT = 8'h09;
      send_block(32'h1111_2222);
      chk("midrst_not_full", {79'd0, bus.donePKT}, 80'd0);
      send_block(32'h3333_4444);
      chk("midrst_donePKT", {79'd0, bus.donePKT}, 80'd1);
      chk("midrst_pkt", bus.out, 80'h88_09_1111_2222_3333_4444);
      ack_pkt(80'h88_09_1111_2222_3333_4444);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
